// File: rtl/my_alu_writeback_stage_if.sv
// Handshake bundle between the ALU, the writeback stage and the register-file write port.
// The master modport is the side that drives the ALU result and consumes the head entry.
interface my_alu_writeback_stage_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_result;
    logic                  in_carry;
    logic                  in_op;
    logic                  in_a_msb;
    logic                  in_b_msb;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [3:0]            out_flags;

    modport master (
        output in_valid, in_result, in_carry, in_op, in_a_msb, in_b_msb, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_result, in_carry, in_op, in_a_msb, in_b_msb, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/my_alu_writeback_stage.sv
// ALU writeback stage: derives N/Z/C/V for each result, buffers result+flags in a
// 2-entry FIFO towards the register file and keeps sticky carry/overflow status.
module my_alu_writeback_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    my_alu_writeback_stage_if.slave        bus,
    input  logic                           clear_sticky,
    output logic                           sticky_c,
    output logic                           sticky_v,
    output logic [1:0]                     occupancy
);
    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [3:0]            flags;   // {N, Z, C, V}
    } entry_t;

    localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

    entry_t     mem_q [2];
    entry_t     in_entry;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       sticky_c_q, sticky_c_d;
    logic       sticky_v_q, sticky_v_d;
    logic       push, pop;
    logic       r_msb, flag_z, flag_v;

    assign r_msb  = bus.in_result[DATA_WIDTH-1];
    assign flag_z = (bus.in_result == '0);

    // Signed overflow: operands of the effective same sign produce a result of the other sign.
    always_comb begin
        if (bus.in_op) flag_v = (bus.in_a_msb != bus.in_b_msb) && (r_msb != bus.in_a_msb);
        else           flag_v = (bus.in_a_msb == bus.in_b_msb) && (r_msb != bus.in_a_msb);
    end

    assign in_entry.result = bus.in_result;
    assign in_entry.flags  = {r_msb, flag_z, bus.in_carry, flag_v};

    assign bus.in_ready   = (count_q < FULL_COUNT);
    assign bus.out_valid  = (count_q != 2'd0);
    assign bus.out_result = mem_q[rd_ptr_q].result;
    assign bus.out_flags  = mem_q[rd_ptr_q].flags;
    assign occupancy      = count_q;
    assign sticky_c       = sticky_c_q;
    assign sticky_v       = sticky_v_q;

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        sticky_c_d = clear_sticky ? 1'b0 : sticky_c_q;
        sticky_v_d = clear_sticky ? 1'b0 : sticky_v_q;

        if (push) begin
            wr_ptr_d   = ~wr_ptr_q;
            sticky_c_d = sticky_c_d | in_entry.flags[1];
            sticky_v_d = sticky_v_d | in_entry.flags[0];
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;

        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two storage entries are reset because the head is visible on the
            // outputs even when empty and must read as zero, never X.
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            sticky_c_q <= 1'b0;
            sticky_v_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (push) mem_q[wr_ptr_q] <= in_entry;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            sticky_c_q <= sticky_c_d;
            sticky_v_q <= sticky_v_d;
        end
    end
endmodule

// File: tb/tb_my_alu_writeback_stage.sv
// Self-checking bench for my_alu_writeback_stage: an ALU model feeds operands, a
// scoreboard queue tracks every accepted entry and is checked as the head is popped.
module tb_my_alu_writeback_stage;
    localparam int DW   = 8;
    localparam int SMAX = (2 ** (DW - 1)) - 1;
    localparam int SMIN = -(2 ** (DW - 1));

    typedef struct packed {
        logic [DW-1:0] result;
        logic [3:0]    flags;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear_sticky = 1'b0;
    logic       sticky_c, sticky_v;
    logic [1:0] occupancy;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    logic [DW-1:0] cur_a = '0;
    logic [DW-1:0] cur_b = '0;
    logic          cur_op = 1'b0;

    my_alu_writeback_stage_if #(.DATA_WIDTH(DW)) bus ();

    my_alu_writeback_stage #(.DATA_WIDTH(DW), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clear_sticky (clear_sticky),
        .sticky_c     (sticky_c),
        .sticky_v     (sticky_v),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion before 100000");
        $fatal(1, "watchdog expired");
    end

    // Reference: true signed arithmetic decides overflow, unsigned width-extension decides carry/borrow.
    function automatic exp_t model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
        int          sa, sb, sr;
        logic [DW:0] wide;
        exp_t        e;
        sa = int'($signed(a));
        sb = int'($signed(b));
        sr = op ? (sa - sb) : (sa + sb);
        wide = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.result = wide[DW-1:0];
        e.flags  = {wide[DW-1], (wide[DW-1:0] == '0), wide[DW], (sr > SMAX) || (sr < SMIN)};
        return e;
    endfunction

    task automatic drive(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic op);
        logic [DW:0] wide;
        cur_a = a;
        cur_b = b;
        cur_op = op;
        wide = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        bus.in_result = wide[DW-1:0];
        bus.in_carry  = wide[DW];
        bus.in_op     = op;
        bus.in_a_msb  = a[DW-1];
        bus.in_b_msb  = b[DW-1];
        bus.in_valid  = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare on pop first, then record any push seen in the same cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: got result %h flags %b, expected no entry", bus.out_result, bus.out_flags);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({bus.out_result, bus.out_flags} !== mon_e) begin
                        miscompares++;
                        $display("FAIL sb_entry: got result %h flags %b, expected result %h flags %b",
                                 bus.out_result, bus.out_flags, mon_e.result, mon_e.flags);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) sb_q.push_back(model(cur_a, cur_b, cur_op));
        end
    end

    task automatic wait_empty(input string name);
        int n = 0;
        while (occupancy != 2'd0 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (occupancy !== 2'd0) begin
            miscompares++;
            $display("FAIL %s_drain: occupancy %0d after %0d cycles, expected 0", name, occupancy, n);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_result = '0;
        bus.in_carry = 1'b0;
        bus.in_op = 1'b0;
        bus.in_a_msb = 1'b0;
        bus.in_b_msb = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy); end
        vectors++; if (bus.out_result !== 8'h00) begin miscompares++; $display("FAIL rst_out_result: got %h expected 00", bus.out_result); end
        vectors++; if (bus.out_flags !== 4'b0000) begin miscompares++; $display("FAIL rst_out_flags: got %b expected 0000", bus.out_flags); end
        vectors++; if ({sticky_c, sticky_v} !== 2'b00) begin miscompares++; $display("FAIL rst_sticky: got %b%b expected 00", sticky_c, sticky_v); end
        tick();
        rst_n = 1'b1;
        tick();
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_flags();
        bus.out_ready = 1'b1;
        drive(8'h7F, 8'h01, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: out_valid %b expected 1", bus.out_valid); end
        vectors++; if (bus.out_result !== 8'h80) begin miscompares++; $display("FAIL add_result: got %h expected 80", bus.out_result); end
        vectors++; if (bus.out_flags !== 4'b1001) begin miscompares++; $display("FAIL add_flags: got %b expected 1001", bus.out_flags); end
        vectors++; if (sticky_v !== 1'b1) begin miscompares++; $display("FAIL add_sticky_v: got %b expected 1", sticky_v); end
        tick();

        drive(8'h05, 8'h05, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.out_flags !== 4'b0100) begin miscompares++; $display("FAIL sub_zero_flags: got %b expected 0100", bus.out_flags); end
        tick();

        drive(8'h03, 8'h05, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.out_flags !== 4'b1010) begin miscompares++; $display("FAIL sub_borrow_flags: got %b expected 1010", bus.out_flags); end
        vectors++; if (sticky_c !== 1'b1) begin miscompares++; $display("FAIL sub_sticky_c: got %b expected 1", sticky_c); end
        tick();

        clear_sticky = 1'b1;
        tick();
        clear_sticky = 1'b0;
        vectors++; if ({sticky_c, sticky_v} !== 2'b00) begin miscompares++; $display("FAIL clear_sticky: got %b%b expected 00", sticky_c, sticky_v); end
        vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL idle_pop_empty: occupancy %0d expected 0", occupancy); end

        // Clear together with a push keeps the new event: C=1 survives, old V=1 is cleared.
        drive(8'h7F, 8'h01, 1'b0);
        tick();
        clear_sticky = 1'b1;
        drive(8'h03, 8'h05, 1'b1);
        tick();
        clear_sticky = 1'b0;
        bus.in_valid = 1'b0;
        vectors++; if ({sticky_c, sticky_v} !== 2'b10) begin miscompares++; $display("FAIL clear_with_push: got %b%b expected 10", sticky_c, sticky_v); end
        wait_empty("flags");
    endtask

    task automatic test_backpressure();
        int  n = 0;
        bit  acc = 1'b0;
        bus.out_ready = 1'b0;
        drive(8'h11, 8'h00, 1'b0);
        tick();
        drive(8'h22, 8'h00, 1'b0);
        tick();
        drive(8'h33, 8'h00, 1'b0);
        @(negedge clk);
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b expected 0", bus.in_ready); end
        vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL full_occupancy: got %0d expected 2", occupancy); end
        vectors++; if (bus.out_result !== 8'h11) begin miscompares++; $display("FAIL full_head_stable: got %h expected 11", bus.out_result); end
        tick();
        vectors++; if (occupancy !== 2'd2) begin miscompares++; $display("FAIL full_no_accept: occupancy %0d expected 2", occupancy); end
        bus.out_ready = 1'b1;
        while (!acc && n < 10) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        vectors++; if (!acc) begin miscompares++; $display("FAIL held_accept: 33 not accepted in %0d cycles, expected acceptance", n); end
        wait_empty("backpressure");
        vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL backpressure_sb: %0d entries left, expected 0", sb_q.size()); end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        drive(8'h40, 8'h00, 1'b0);
        tick();
        drive(8'h44, 8'h00, 1'b0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL b2b_pre_occupancy: got %0d expected 1", occupancy); end
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        vectors++; if (occupancy !== 2'd1) begin miscompares++; $display("FAIL b2b_occupancy: got %0d expected 1", occupancy); end
        vectors++; if (bus.out_result !== 8'h44) begin miscompares++; $display("FAIL b2b_head: got %h expected 44", bus.out_result); end
        tick();
        bus.out_ready = 1'b1;
        wait_empty("b2b");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(8'h80, 8'h80, 1'b0);
        tick();
        drive(8'h60, 8'h00, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++; if ({occupancy, sticky_c, sticky_v} !== 4'b1011) begin miscompares++; $display("FAIL pre_reset_state: got occ %0d sticky %b%b expected occ 2 sticky 11", occupancy, sticky_c, sticky_v); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_out_valid: got %b expected 0", bus.out_valid); end
        vectors++; if (occupancy !== 2'd0) begin miscompares++; $display("FAIL mid_rst_occupancy: got %0d expected 0", occupancy); end
        vectors++; if ({sticky_c, sticky_v} !== 2'b00) begin miscompares++; $display("FAIL mid_rst_sticky: got %b%b expected 00", sticky_c, sticky_v); end
        vectors++; if (bus.out_result !== 8'h00) begin miscompares++; $display("FAIL mid_rst_result: got %h expected 00", bus.out_result); end
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        drive(8'h55, 8'h00, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL post_rst_valid: got %b expected 1", bus.out_valid); end
        vectors++; if (bus.out_result !== 8'h55) begin miscompares++; $display("FAIL post_rst_result: got %h expected 55", bus.out_result); end
        tick();
        bus.out_ready = 1'b1;
        wait_empty("post_rst");
        vectors++; if (sb_q.size() != 0) begin miscompares++; $display("FAIL final_sb: %0d entries left, expected 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
